// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: decode match,
// funct3 op codes, FSM state encodings and operand-signedness helpers.
package muldiv_seq_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // mulhsu treats only the multiplicand as signed
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add / restoring shift-subtract datapath on operand magnitudes,
// with special-case detection on the raw operands and the final sign fix.
module muldiv_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             special_o,
  output logic [WIDTH-1:0] special_res_o,
  output logic [WIDTH-1:0] fix_res_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;

  logic               sa_s, sb_s, b_zero_s, ovf_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     sum_s, shifted_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign sa_s    = a_is_signed(funct3_i) & a_i[WIDTH-1];
  assign sb_s    = b_is_signed(funct3_i) & b_i[WIDTH-1];
  assign mag_a_s = sa_s ? -a_i : a_i;
  assign mag_b_s = sb_s ? -b_i : b_i;

  assign b_zero_s = (b_i == '0);
  assign ovf_s    = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                    (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == {WIDTH{1'b1}});

  // funct3[1] separates rem/remu from div/divu among the divide ops
  always_comb begin
    special_o     = 1'b0;
    special_res_o = '0;
    if (funct3_i[2] && b_zero_s) begin
      special_o     = 1'b1;
      special_res_o = funct3_i[1] ? a_i : {WIDTH{1'b1}};
    end else if (funct3_i[2] && ovf_s) begin
      special_o     = 1'b1;
      special_res_o = funct3_i[1] ? '0 : a_i;
    end else begin
      special_o     = 1'b0;
    end
  end

  // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}
  assign sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign shifted_s = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff_s    = shifted_s - {1'b0, opnd_q};

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    sa_d   = sa_q;
    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, (funct3_i[2] ? mag_a_s : mag_b_s)};
      opnd_d = funct3_i[2] ? mag_b_s : mag_a_s;
      f3_d   = funct3_i;
      neg_d  = sa_s ^ sb_s;
      sa_d   = sa_s;
    end else if (step_i && !f3_q[2]) begin
      acc_d = {sum_s, acc_q[WIDTH-1:1]};
    end else if (step_i) begin
      acc_d = diff_s[WIDTH] ? {shifted_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      f3_q   <= 3'd0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      sa_q   <= sa_d;
    end
  end

  assign prod_s = neg_q ? -acc_q : acc_q;
  assign quo_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    case (f3_q)
      F3_MUL:                       fix_res_o = prod_s[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_o = prod_s[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              fix_res_o = quo_s;
      F3_REM, F3_REMU:              fix_res_o = rem_s;
      default:                      fix_res_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: IDLE -> CALC (32 steps) -> FIX -> DONE,
// with one-cycle special cases, pipeline kill and zero-bubble back-to-back issue.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept_s, load_s, step_s, special_s;
  logic [WIDTH-1:0] special_res_s, fix_res_s;

  assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !kill;

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_s),
    .step_i        (step_s),
    .funct3_i      (funct3),
    .a_i           (rs1_val),
    .b_i           (rs2_val),
    .special_o     (special_s),
    .special_res_o (special_res_s),
    .fix_res_o     (fix_res_s)
  );

  // kill overrides everything and leaves result untouched
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    load_s   = 1'b0;
    step_s   = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && accept_s) begin
            load_s = 1'b1;
            cnt_d  = '0;
            if (special_s) begin
              state_d  = ST_DONE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              result_d = special_res_s;
            end else begin
              state_d = ST_CALC;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        ST_CALC: begin
          step_s = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_FIX: begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = fix_res_s;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = busy_q | (start & accept_s);

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide ops that the single-cycle ALU cannot execute.
- Sits beside the ALU in the execute stage. Decode routes funct7=0x01 R-type ops here with operands and funct3.
- Stalls the core via `stall` until `done`. Result is written back in the `done` cycle.
- Iterative radix-2 datapath: one bit per cycle on operand magnitudes, with a sign-fix step.

Parameters:
- WIDTH, 32, operand/result width (only 32 is supported).
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request, qualified by funct3/rs1_val/rs2_val
- funct3  input  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
- rs1_val  input  32  operand A (multiplicand/dividend)
- rs2_val  input  32  operand B (multiplier/divisor)
- kill  input  1  pipeline flush; abandons the current op
- busy  output  1  registered; high in CALC and FIX
- stall  output  1  combinational: busy | (start & accept)
- done  output  1  registered; one-cycle pulse, result valid
- result  output  32  registered; holds its value until the next done

Behaviour:
- Reset: every edge with rst_n=0 forces state=IDLE, busy=0, done=0, result=0, and clears internal registers. Reset mid-operation aborts without done.
- States: IDLE, CALC, FIX, DONE. accept = state is IDLE or DONE, and kill=0.
- IDLE/DONE + start + accept: capture funct3, operand magnitudes and sign flags (signedness per funct3); count=0.
  - Normal case: next state CALC.
  - Special case: next state DONE with result loaded directly.
- Special cases, latency 1 (done high in the cycle after the capture edge):
  - div/divu with B=0: result=0xFFFFFFFF.
  - rem/remu with B=0: result=A.
  - div with A=0x80000000, B=0xFFFFFFFF: result=0x80000000.
  - rem with that same A/B pair: result=0.
- CALC, multiply: 64-bit shift-add of |A|·|B|, one multiplier bit per edge.
- CALC, divide: restoring shift-subtract, one quotient bit per edge.
- CALC: count increments each edge. When count=WIDTH-1, next state is FIX.
- FIX: negate the product if signs differ (mulh/mulhsu; mul is low word, sign-corrected).
  - Quotient sign = sA^sB; remainder sign = sA.
  - Select low/high word or quotient/remainder. Register into result, set done, go to DONE.
- Normal latency: the capture edge plus 32 CALC edges plus 1 FIX edge. done is high in the 34th cycle after the start cycle.
- Back-to-back: done=1, state=DONE, and start accepted in the same cycle gives zero bubble.
- DONE without start: next state IDLE, done=0.
- start while busy: ignored, no queueing. Decode keeps start asserted because stall=1.
- kill: when sampled high, next state IDLE, busy=0, done=0, result unchanged. kill has priority over start and over FIX completion.
- Arithmetic: all widths exactly 32/64 bits. Negation is two's complement. mulhsu treats only A as signed.

Decomposition:
- Shared package:
  - funct3 constants F3_MUL..F3_REMU
  - state enum encoding (IDLE=0, CALC=1, FIX=2, DONE=3)
  - MULDIV_FUNCT7=7'h01 for decode
- Sub-module: muldiv_datapath (accumulator/shift registers, step add/subtract, sign fix), driven by the FSM in muldiv_seq.

Test Plan:
- mul A=7, B=0xFFFFFFFD -> result=0xFFFFFFEB, done exactly 34 cycles after the start cycle, busy high for 33 cycles.
- Multiply high words:
  - mulh 0x80000000×0x80000000 -> 0x40000000.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- Signed division:
  - div 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - rem same operands -> 0xFFFFFFFF.
  - divu 100/7 -> 14; remu -> 2.
- Special cases:
  - divu 5/0 -> 0xFFFFFFFF.
  - rem 5/0 -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000.
  - All three have done 1 cycle after start, busy never high.
- kill asserted 10 cycles into a div -> no done pulse, IDLE next cycle, result keeps its previous value. A start with kill high is ignored.
- Control corner cases:
  - start pulsed mid-CALC -> ignored.
  - start on the done cycle -> second op completes 34 cycles later.
  - rst_n low mid-CALC -> all outputs 0 next cycle.
